ps2_letter_decoder: RTL and testbench

Upstream input stage of the hangman datapath. Receives the raw PS/2 keyboard clock/data pins, deserializes and checks scan-code frames, and tracks break (F0) and extended (E0) prefixes. Converts letter make codes into the 5-bit letter code the datapath consumes on its `char`/`guess` inputs (A=1 … Z=26), plus one-cycle Enter and Backspace strobes for the control FSM. Auto-repeat is suppressed, so one physical key press yields exactly one strobe.

---
 rtl/hangman_pkg.sv | 35 +++
 rtl/ps2_letter_decoder_rx.sv | 89 ++++++++
 rtl/ps2_letter_decoder.sv | 89 ++++++++
 tb/tb_ps2_letter_decoder.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/hangman_pkg.sv
// Shared hangman definitions: letter-code width, PS/2 set-2 scan codes
// and the receiver state encoding.
package hangman_pkg;

    localparam int LETTER_W = 5;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_BKSP  = 8'h66;

    // Set-2 make codes for A..Z, index i maps to letter code i+1
    localparam logic [7:0] LETTER_SC [26] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
        8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
        8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A
    };

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    function automatic logic [LETTER_W-1:0] letter_code(input logic [7:0] sc);
        logic [LETTER_W-1:0] code;
        code = '0;
        for (int i = 0; i < 26; i++) begin
            if (LETTER_SC[i] == sc) code = LETTER_W'(i + 1);
        end
        return code;
    endfunction

endpackage

// File: rtl/ps2_letter_decoder_rx.sv
// PS/2 frame receiver: pin synchronizers, falling-edge detect,
// start/data/parity/stop FSM and inter-edge watchdog.
import hangman_pkg::*;

module ps2_rx #(
    parameter int WATCHDOG_CYC = 50000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_err,
    output logic       busy
);

    localparam int WD_W = $clog2(WATCHDOG_CYC + 1);

    logic            clk_s1, clk_s2, clk_prev;
    logic            dat_s1, dat_s2;
    logic            fall, wd_hit, stop_ok, at_stop;
    rx_state_t       state;
    logic [2:0]      cnt;
    logic [7:0]      sr;
    logic            par;
    logic [WD_W-1:0] wd;

    assign fall    = clk_prev & ~clk_s2;
    assign wd_hit  = (state != RX_IDLE) && !fall
                     && (wd == WD_W'(WATCHDOG_CYC - 1));
    assign stop_ok = dat_s2 & (^{sr, par});
    assign at_stop = fall && (state == RX_STOP);

    // Byte/error are combinational so the top can register them in D+1
    assign rx_byte  = sr;
    assign rx_valid = at_stop && stop_ok;
    assign rx_err   = (at_stop && !stop_ok) || wd_hit;
    assign busy     = (state != RX_IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
            state    <= RX_IDLE;
            cnt      <= '0;
            sr       <= '0;
            par      <= 1'b0;
            wd       <= '0;
        end else begin
            clk_s1   <= ps2_clk;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= ps2_data;
            dat_s2   <= dat_s1;

            if (fall || wd_hit || state == RX_IDLE) wd <= '0;
            else                                    wd <= wd + 1'b1;

            if (wd_hit) begin
                state <= RX_IDLE;
            end else if (fall) begin
                unique case (state)
                    RX_IDLE: begin
                        if (!dat_s2) begin
                            state <= RX_DATA;
                            cnt   <= '0;
                        end
                    end
                    RX_DATA: begin
                        sr  <= {dat_s2, sr[7:1]};
                        cnt <= cnt + 1'b1;
                        if (cnt == 3'd7) state <= RX_PARITY;
                    end
                    RX_PARITY: begin
                        par   <= dat_s2;
                        state <= RX_STOP;
                    end
                    RX_STOP: state <= RX_IDLE;
                    default: state <= RX_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/ps2_letter_decoder.sv
// Hangman keyboard front end: turns PS/2 scan codes into letter codes
// plus Enter/Backspace strobes, with break/extended and repeat handling.
import hangman_pkg::*;

module ps2_letter_decoder #(
    parameter int WATCHDOG_CYC = 50000
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                ps2_clk,
    input  logic                ps2_data,
    output logic [LETTER_W-1:0] char,
    output logic                char_valid,
    output logic                key_enter,
    output logic                key_backspace,
    output logic                frame_err,
    output logic                busy
);

    logic [7:0]          rx_byte;
    logic                rx_valid, rx_err;
    logic                brk, ext, held_v;
    logic [7:0]          held;
    logic                repeat_hit;
    logic [LETTER_W-1:0] code;

    ps2_rx #(
        .WATCHDOG_CYC(WATCHDOG_CYC)
    ) u_rx (
        .clk     (clk),
        .resetn  (resetn),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .rx_byte (rx_byte),
        .rx_valid(rx_valid),
        .rx_err  (rx_err),
        .busy    (busy)
    );

    assign repeat_hit = held_v && (rx_byte == held);
    assign code       = letter_code(rx_byte);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            char          <= '0;
            char_valid    <= 1'b0;
            key_enter     <= 1'b0;
            key_backspace <= 1'b0;
            frame_err     <= 1'b0;
            brk           <= 1'b0;
            ext           <= 1'b0;
            held_v        <= 1'b0;
            held          <= '0;
        end else begin
            char_valid    <= 1'b0;
            key_enter     <= 1'b0;
            key_backspace <= 1'b0;
            frame_err     <= 1'b0;
            if (rx_err) begin
                frame_err <= 1'b1;
                brk       <= 1'b0;
                ext       <= 1'b0;
            end else if (rx_valid) begin
                if (rx_byte == SC_BREAK) begin
                    brk <= 1'b1;
                end else if (rx_byte == SC_EXT) begin
                    ext <= 1'b1;
                end else if (brk) begin
                    // Release of the held key re-arms it for the next press
                    if (repeat_hit) held_v <= 1'b0;
                    brk <= 1'b0;
                    ext <= 1'b0;
                end else if (ext) begin
                    ext <= 1'b0;
                end else if (!repeat_hit) begin
                    held          <= rx_byte;
                    held_v        <= 1'b1;
                    key_enter     <= (rx_byte == SC_ENTER);
                    key_backspace <= (rx_byte == SC_BKSP);
                    if (code != '0) begin
                        char       <= code;
                        char_valid <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_letter_decoder.sv
// Directed bench for ps2_letter_decoder: table of frames with expected
// strobe counts, plus watchdog and reset-mid-frame sequences.
module tb_ps2_letter_decoder;

    localparam int WD = 400;
    localparam int H  = 10;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [4:0] char;
    logic       char_valid, key_enter, key_backspace, frame_err, busy;

    int cyc = 0;
    int n_chr = 0, n_ent = 0, n_bks = 0, n_err = 0, excl_viol = 0;
    int chr_cyc = 0, last_fall = 0;
    int n_pass = 0, n_tot = 0;

    ps2_letter_decoder #(.WATCHDOG_CYC(WD)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .char         (char),
        .char_valid   (char_valid),
        .key_enter    (key_enter),
        .key_backspace(key_backspace),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (char_valid) begin
            n_chr   = n_chr + 1;
            chr_cyc = cyc;
        end
        if (key_enter)     n_ent = n_ent + 1;
        if (key_backspace) n_bks = n_bks + 1;
        if (frame_err)     n_err = n_err + 1;
        if ($countones({char_valid, key_enter, key_backspace, frame_err}) > 1)
            excl_viol = excl_viol + 1;
    end

    typedef struct {
        logic [7:0] sc;
        bit         bad_par;
        bit         bad_stop;
        int         e_chr;
        int         e_ent;
        int         e_bks;
        int         e_err;
        int         e_char;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input int act, input int exp);
        n_tot = n_tot + 1;
        if (act == exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic clr();
        n_chr = 0; n_ent = 0; n_bks = 0; n_err = 0;
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ps2_data = bits[i];
            repeat (H) @(negedge clk);
            ps2_clk   = 1'b0;
            last_fall = cyc;
            repeat (H) @(negedge clk);
            ps2_clk = 1'b1;
        end
        @(negedge clk);
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] sc, input bit bp, input bit bs);
        logic par;
        par = ~(^sc) ^ bp;
        send_bits({~bs, par, sc, 1'b0}, 11);
        repeat (20) @(negedge clk);
    endtask

    initial begin
        vecs[0]  = '{8'h1C, 0, 0, 1, 0, 0, 0, 1};
        vecs[1]  = '{8'h1C, 0, 0, 0, 0, 0, 0, 1};
        vecs[2]  = '{8'h1C, 0, 0, 0, 0, 0, 0, 1};
        vecs[3]  = '{8'hF0, 0, 0, 0, 0, 0, 0, 1};
        vecs[4]  = '{8'h1C, 0, 0, 0, 0, 0, 0, 1};
        vecs[5]  = '{8'h1C, 0, 0, 1, 0, 0, 0, 1};
        vecs[6]  = '{8'h1A, 0, 0, 1, 0, 0, 0, 26};
        vecs[7]  = '{8'h5A, 0, 0, 0, 1, 0, 0, 26};
        vecs[8]  = '{8'h66, 0, 0, 0, 0, 1, 0, 26};
        vecs[9]  = '{8'hE0, 0, 0, 0, 0, 0, 0, 26};
        vecs[10] = '{8'h1C, 0, 0, 0, 0, 0, 0, 26};
        vecs[11] = '{8'hF0, 0, 0, 0, 0, 0, 0, 26};
        vecs[12] = '{8'h5A, 0, 0, 0, 0, 0, 0, 26};
        vecs[13] = '{8'h1C, 1, 0, 0, 0, 0, 1, 26};
        vecs[14] = '{8'h24, 0, 1, 0, 0, 0, 1, 26};
        vecs[15] = '{8'h24, 0, 0, 1, 0, 0, 0, 5};

        repeat (3) @(negedge clk);
        chk("reset_outs",
            int'({char, char_valid, key_enter, key_backspace, frame_err, busy}), 0);
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        clr();

        for (int i = 0; i < 16; i++) begin
            clr();
            send_frame(vecs[i].sc, vecs[i].bad_par, vecs[i].bad_stop);
            chk($sformatf("v%0d_chr", i), n_chr, vecs[i].e_chr);
            chk($sformatf("v%0d_ent", i), n_ent, vecs[i].e_ent);
            chk($sformatf("v%0d_bks", i), n_bks, vecs[i].e_bks);
            chk($sformatf("v%0d_err", i), n_err, vecs[i].e_err);
            chk($sformatf("v%0d_char", i), int'(char), vecs[i].e_char);
            if (vecs[i].e_chr == 1 && n_chr == 1)
                chk($sformatf("v%0d_latency_ok", i),
                    int'((chr_cyc - last_fall) >= 3 && (chr_cyc - last_fall) <= 4), 1);
        end

        // Glitch start: start bit plus three data bits, then silence
        clr();
        send_bits(11'b000_0000_1010, 4);
        repeat (5) @(negedge clk);
        chk("wd_busy_mid", int'(busy), 1);
        repeat (WD + 10) @(negedge clk);
        chk("wd_err", n_err, 1);
        chk("wd_busy_low", int'(busy), 0);
        chk("wd_no_char", n_chr, 0);
        clr();
        send_frame(8'h32, 0, 0);
        chk("wd_next_chr", n_chr, 1);
        chk("wd_next_char", int'(char), 2);
        chk("wd_next_err", n_err, 0);

        // Reset while the receiver is in DATA
        clr();
        send_bits(11'b000_0000_0010, 3);
        repeat (5) @(negedge clk);
        chk("rst_mid_busy", int'(busy), 1);
        resetn = 1'b0;
        #1;
        chk("rst_mid_outs",
            int'({char, char_valid, key_enter, key_backspace, frame_err, busy}), 0);
        repeat (4) @(negedge clk);
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        clr();
        send_frame(8'h15, 0, 0);
        chk("rst_next_chr", n_chr, 1);
        chk("rst_next_char", int'(char), 17);
        chk("rst_next_err", n_err, 0);

        chk("strobe_exclusive", excl_viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
